// File: rtl/ltc2992_poll_seq.sv
// ltc2992_poll_seq: polls four LTC2992 ADC result registers through the I2C
// register-read engine at a fixed sweep period. Each read is bounded by a
// timeout and publishes a channel-tagged 12-bit result with a valid strobe.
module ltc2992_poll_seq #(
    parameter logic [6:0]  P_DEV_ADDR    = 7'h6F,
    parameter logic [23:0] P_PERIOD_CYC  = 24'd1_000_000,
    parameter logic [19:0] P_TIMEOUT_CYC = 20'd200_000,
    parameter logic [3:0]  P_GAP_CYC     = 4'd4
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_start_en,
    input  logic        I_recv_done,
    input  logic [15:0] I_recv_data,
    output logic        O_recv_en,
    output logic [6:0]  O_dev_addr,
    output logic [7:0]  O_word_addr,
    output logic [1:0]  O_BYTE,
    output logic [1:0]  O_ch_id,
    output logic [11:0] O_ch_data,
    output logic        O_ch_valid,
    output logic        O_timeout,
    output logic [7:0]  O_err_cnt,
    output logic        O_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_GAP,
        S_WAIT_PERIOD
    } state_t;

    // The period counter is loaded on the edge leaving ISSUE and is tested in
    // WAIT_PERIOD one cycle ahead of the next ISSUE, so the next channel-0
    // ISSUE lands exactly P_PERIOD_CYC cycles after the previous one.
    localparam logic [23:0] PER_LOAD  = P_PERIOD_CYC - 24'd2;
    localparam logic [19:0] TMO_LAST  = P_TIMEOUT_CYC - 20'd1;
    // GAP lasts P_GAP_CYC-1 cycles; the ISSUE cycle supplies the last low cycle.
    localparam logic [3:0]  GAP_LAST  = P_GAP_CYC - 4'd2;

    state_t      state_q, state_d;
    logic [1:0]  ch_idx_q, ch_idx_d;
    logic        start_q, start_d;
    logic [23:0] per_q, per_d;
    logic [19:0] tmo_q, tmo_d;
    logic [3:0]  gap_q, gap_d;
    logic        recv_en_q, recv_en_d;
    logic [7:0]  word_addr_q, word_addr_d;
    logic [1:0]  ch_id_q, ch_id_d;
    logic [11:0] ch_data_q, ch_data_d;
    logic        ch_valid_q, ch_valid_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    function automatic logic [7:0] reg_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    reg_addr = 8'h14;  // delta-SENSE1 MSB
            2'd1:    reg_addr = 8'h1E;  // SENSE1 MSB
            2'd2:    reg_addr = 8'h46;  // delta-SENSE2 MSB
            default: reg_addr = 8'h50;  // SENSE2 MSB
        endcase
    endfunction

    // Next-state and registered-output computation for the polling FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        ch_idx_d    = ch_idx_q;
        start_d     = I_start_en;
        per_d       = (per_q != 24'd0) ? per_q - 24'd1 : 24'd0;
        tmo_d       = tmo_q;
        gap_d       = gap_q;
        recv_en_d   = recv_en_q;
        word_addr_d = word_addr_q;
        ch_id_d     = ch_id_q;
        ch_data_d   = ch_data_q;
        ch_valid_d  = 1'b0;
        timeout_d   = 1'b0;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            S_IDLE: begin
                recv_en_d = 1'b0;
                per_d     = 24'd0;
                // Start needs the enable seen on two consecutive edges.
                if (start_q && I_start_en) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ch_idx_q == 2'd0) begin
                    per_d = PER_LOAD;
                end
                word_addr_d = reg_addr(ch_idx_q);
                recv_en_d   = 1'b1;
                tmo_d       = 20'd0;
                state_d     = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                tmo_d = tmo_q + 20'd1;
                if (I_recv_done) begin
                    // Done wins over a coincident timeout.
                    ch_data_d  = I_recv_data[15:4];
                    ch_id_d    = ch_idx_q;
                    ch_valid_d = 1'b1;
                    recv_en_d  = 1'b0;
                    gap_d      = 4'd0;
                    state_d    = S_GAP;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                    recv_en_d = 1'b0;
                    gap_d     = 4'd0;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (ch_idx_q == 2'd3) begin
                        ch_idx_d = 2'd0;
                        state_d  = S_WAIT_PERIOD;
                    end else begin
                        ch_idx_d = ch_idx_q + 2'd1;
                        state_d  = S_ISSUE;
                    end
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            S_WAIT_PERIOD: begin
                if (per_q == 24'd0) begin
                    state_d = S_ISSUE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Dropping the enable aborts from any state; results and error count stay.
        if (!I_start_en) begin
            state_d    = S_IDLE;
            recv_en_d  = 1'b0;
            ch_idx_d   = 2'd0;
            per_d      = 24'd0;
            tmo_d      = 20'd0;
            gap_d      = 4'd0;
            ch_valid_d = 1'b0;
            timeout_d  = 1'b0;
            ch_id_d    = ch_id_q;
            ch_data_d  = ch_data_q;
            err_cnt_d  = err_cnt_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            // NOTE: every flop here is a control/status register, so all get a reset value.
            state_q     <= S_IDLE;
            ch_idx_q    <= 2'd0;
            start_q     <= 1'b0;
            per_q       <= 24'd0;
            tmo_q       <= 20'd0;
            gap_q       <= 4'd0;
            recv_en_q   <= 1'b0;
            word_addr_q <= 8'd0;
            ch_id_q     <= 2'd0;
            ch_data_q   <= 12'd0;
            ch_valid_q  <= 1'b0;
            timeout_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            ch_idx_q    <= ch_idx_d;
            start_q     <= start_d;
            per_q       <= per_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
            recv_en_q   <= recv_en_d;
            word_addr_q <= word_addr_d;
            ch_id_q     <= ch_id_d;
            ch_data_q   <= ch_data_d;
            ch_valid_q  <= ch_valid_d;
            timeout_q   <= timeout_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign O_recv_en   = recv_en_q;
    assign O_dev_addr  = P_DEV_ADDR;
    assign O_word_addr = word_addr_q;
    assign O_BYTE      = 2'd2;
    assign O_ch_id     = ch_id_q;
    assign O_ch_data   = ch_data_q;
    assign O_ch_valid  = ch_valid_q;
    assign O_timeout   = timeout_q;
    assign O_err_cnt   = err_cnt_q;
    assign O_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ltc2992_poll_seq.sv
// Scoreboard bench for ltc2992_poll_seq: a read-engine model answers each
// enable with a random latency, a reference model predicts every strobe, and
// a monitor process compares strobes against the queued predictions.
module tb_ltc2992_poll_seq;

    localparam int P = 200;
    localparam int T = 60;
    localparam int G = 3;

    logic        clk = 1'b0;
    logic        rst_n, start_en, done;
    logic [15:0] rdata;
    logic        recv_en, ch_valid, tmo_strobe, busy;
    logic [6:0]  dev_addr;
    logic [7:0]  word_addr, err_cnt;
    logic [1:0]  byte_cnt, ch_id;
    logic [11:0] ch_data;

    always #5 clk = ~clk;

    ltc2992_poll_seq #(
        .P_DEV_ADDR    (7'h6F),
        .P_PERIOD_CYC  (24'(P)),
        .P_TIMEOUT_CYC (20'(T)),
        .P_GAP_CYC     (4'(G))
    ) dut (
        .I_clk       (clk),
        .I_rst_n     (rst_n),
        .I_start_en  (start_en),
        .I_recv_done (done),
        .I_recv_data (rdata),
        .O_recv_en   (recv_en),
        .O_dev_addr  (dev_addr),
        .O_word_addr (word_addr),
        .O_BYTE      (byte_cnt),
        .O_ch_id     (ch_id),
        .O_ch_data   (ch_data),
        .O_ch_valid  (ch_valid),
        .O_timeout   (tmo_strobe),
        .O_err_cnt   (err_cnt),
        .O_busy      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Edge counter; stable when read on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_tmo;
        int          ch;
        logic [11:0] data;
        int          due;
        int          err;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  tbl [4] = '{8'h14, 8'h1E, 8'h46, 8'h50};

    // Reference-model state
    int          mode = 0;      // 0 fast replies, 1 mixed, 2 engine dead
    int          m_ch = 0;
    int          m_err = 0;
    logic [11:0] last_data = 12'd0;
    int          saved_err = 0;
    logic [11:0] saved_data = 12'd0;
    int          n_sweep = 0;
    int          n_tmo = 0;
    int          prev0 = 0;
    bit          have0 = 0;
    int          last_fall = 0;
    bit          en_d = 0;
    int          resp_cyc = -1;
    logic [15:0] resp_data = 16'd0;

    // Read-engine model and reference model: reacts to each enable rise.
    always @(negedge clk) begin
        int   lat;
        int   r;
        int   exp_rise;
        logic [15:0] d;
        exp_t e;
        done = 1'b0;
        if (!busy) begin
            if (sb.size() > 0) begin
                sb.delete();
                m_err     = saved_err;
                last_data = saved_data;
            end
            resp_cyc = -1;
            m_ch     = 0;
            have0    = 0;
            en_d     = 0;
        end else begin
            if (recv_en && !en_d) begin
                check("word_addr", 32'(word_addr), 32'(tbl[m_ch]));
                if (m_ch != 0) begin
                    check("gap_len", 32'(cyc - last_fall), 32'(G));
                end else if (have0) begin
                    exp_rise = (prev0 + P > last_fall + G + 1) ? prev0 + P : last_fall + G + 1;
                    check("ch0_reissue_cycle", 32'(cyc), 32'(exp_rise));
                end
                if (m_ch == 0) begin
                    prev0 = cyc;
                    have0 = 1;
                    n_sweep++;
                end
                if (mode == 0) begin
                    lat = $urandom_range(1, 20);
                    d   = {12'hABC, 4'($urandom)};
                end else if (mode == 1) begin
                    r = $urandom_range(0, 9);
                    case (r)
                        0:       lat = 0;                            // no reply
                        1:       lat = T;                            // coincides with last timeout cycle
                        2:       lat = $urandom_range(T + 1, T + G - 1); // stray done in gap
                        3:       lat = T - 1;
                        default: lat = $urandom_range(1, T - 2);
                    endcase
                    d = 16'($urandom);
                end else begin
                    lat = 0;
                    d   = 16'($urandom);
                end
                saved_err  = m_err;
                saved_data = last_data;
                e.ch = m_ch;
                if (lat >= 1 && lat <= T) begin
                    e.is_tmo  = 0;
                    e.data    = d[15:4];
                    e.due     = cyc + lat;
                    last_data = d[15:4];
                end else begin
                    e.is_tmo = 1;
                    e.data   = last_data;
                    e.due    = cyc + T;
                    m_err    = (m_err < 255) ? m_err + 1 : 255;
                    n_tmo++;
                end
                e.err = m_err;
                sb.push_back(e);
                if (lat > 0) begin
                    resp_cyc  = cyc + lat - 1;
                    resp_data = d;
                end
                m_ch = (m_ch + 1) % 4;
            end
            if (!recv_en && en_d) last_fall = cyc;
            if (cyc == resp_cyc) begin
                done     = 1'b1;
                rdata    = resp_data;
                resp_cyc = -1;
            end
            en_d = recv_en;
        end
    end

    // Monitor: pops one prediction per strobe and compares.
    always @(negedge clk) begin
        exp_t e;
        if (ch_valid || tmo_strobe) begin
            check("recv_en_low_on_strobe", 32'(recv_en), 32'd0);
            if (sb.size() == 0) begin
                check("strobe_without_txn", 32'(ch_valid | tmo_strobe), 32'd0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind_timeout", 32'(tmo_strobe), 32'(e.is_tmo));
                check("strobe_kind_valid", 32'(ch_valid), 32'(!e.is_tmo));
                check("strobe_cycle", 32'(cyc), 32'(e.due));
                if (!e.is_tmo) check("ch_id", 32'(ch_id), 32'(e.ch));
                check("ch_data", 32'(ch_data), 32'(e.data));
                check("err_cnt", 32'(err_cnt), 32'(e.err));
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            check("missing_strobe", 32'(ch_valid | tmo_strobe), 32'd1);
            void'(sb.pop_front());
        end
    end

    initial begin
        int lim;
        rst_n    = 1'b0;
        start_en = 1'b0;
        done     = 1'b0;
        rdata    = 16'd0;
        repeat (4) @(negedge clk);
        check("rst_recv_en", 32'(recv_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dev_addr", 32'(dev_addr), 32'h6F);
        check("rst_byte", 32'(byte_cnt), 32'd2);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_ch_valid", 32'(ch_valid), 32'd0);
        check("rst_timeout", 32'(tmo_strobe), 32'd0);
        check("rst_ch_data", 32'(ch_data), 32'd0);
        check("rst_ch_id", 32'(ch_id), 32'd0);
        check("rst_word_addr", 32'(word_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Start latency: busy after n+1, enable and address after n+2.
        start_en = 1'b1;
        @(negedge clk);
        check("busy_after_n", 32'(busy), 32'd0);
        @(negedge clk);
        check("busy_after_n1", 32'(busy), 32'd1);
        check("recv_en_after_n1", 32'(recv_en), 32'd0);
        @(negedge clk);
        check("recv_en_after_n2", 32'(recv_en), 32'd1);
        check("word_addr_after_n2", 32'(word_addr), 32'h14);

        // Fast replies: sweeps shorter than the period.
        lim = 0;
        while (n_sweep < 6 && lim < 5000) begin @(negedge clk); lim++; end
        check("fast_phase_in_budget", 32'(n_sweep >= 6), 32'd1);

        // Mixed replies, timeouts, coincident done, stray done in gap.
        mode = 1;
        repeat (3000) @(negedge clk);

        // Dead engine: sweeps longer than the period, error count saturates.
        mode = 2;
        lim = 0;
        while (n_tmo < 300 && lim < 40000) begin @(negedge clk); lim++; end
        check("dead_phase_in_budget", 32'(n_tmo >= 300), 32'd1);
        repeat (T + 5) @(negedge clk);
        check("err_cnt_saturated", 32'(err_cnt), 32'd255);

        // Drop enable mid-wait.
        lim = 0;
        while (!recv_en && lim < 500) begin @(negedge clk); lim++; end
        check("recv_en_seen_before_stop", 32'(recv_en), 32'd1);
        repeat (5) @(negedge clk);
        start_en = 1'b0;
        @(negedge clk);
        check("stop_recv_en", 32'(recv_en), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_err_kept", 32'(err_cnt), 32'd255);
        check("stop_data_kept", 32'(ch_data), 32'(last_data));
        repeat (5) @(negedge clk);
        check("stays_idle", 32'(busy), 32'd0);

        // Restart begins at channel 0.
        mode = 0;
        start_en = 1'b1;
        lim = 0;
        while (!recv_en && lim < 10) begin @(negedge clk); lim++; end
        check("restart_recv_en", 32'(recv_en), 32'd1);
        check("restart_word_addr", 32'(word_addr), 32'h14);
        repeat (300) @(negedge clk);

        // Synchronous reset mid-transaction.
        lim = 0;
        while (!recv_en && lim < 200) begin @(negedge clk); lim++; end
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_recv_en", 32'(recv_en), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_err_cnt", 32'(err_cnt), 32'd0);
        check("midreset_ch_data", 32'(ch_data), 32'd0);
        repeat (2) @(negedge clk);
        m_err     = 0;
        last_data = 12'd0;
        rst_n = 1'b1;
        repeat (600) @(negedge clk);

        start_en = 1'b0;
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
